audio_writemem: RTL and testbench

//  Audio capture write-back buffer. It packs a stream of 16-bit samples into
//  8-bit bytes, gathers them into 64-byte lines and writes each line to SDRAM
//  as one 16-word burst.
//  It is the write-side counterpart of the audio read path, and uses the same

---
 rtl/audio_writemem_if.sv | 42 ++++
 rtl/audio_writemem.sv | 230 +++++++++++++++++++++++
 tb/tb_audio_writemem.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_writemem_if.sv
// ---------------------------------------------------------------------------
// audio_writemem_if
//   SDRAM burst-write port between the audio capture write-back buffer
//   (master) and one SDRAM controller write port (slave).
//
//   Handshake:
//   - Request phase: the master raises sdram_request with sdram_address stable.
//     It holds both until a cycle where sdram_request & sdram_ready are both 1.
//     That cycle transfers the request, and the master drops sdram_request on
//     the next edge.
//   - Data phase: sdram_wdata shows the current burst word. A cycle with
//     sdram_wnext=1 means the controller consumed that word, and the master
//     advances. sdram_complete=1 for one cycle ends the burst.
//
//   Signals:
//     sdram_request  master->slave  burst-write request
//     sdram_ready    slave->master  request accepted this cycle
//     sdram_address  master->slave  64-byte aligned line address
//     sdram_wdata    master->slave  current burst word
//     sdram_wnext    slave->master  current word consumed
//     sdram_complete slave->master  burst finished
// ---------------------------------------------------------------------------
interface audio_writemem_if #(
    parameter int ADDR_W = 26
) ();
    logic              sdram_request;
    logic              sdram_ready;
    logic [ADDR_W-1:0] sdram_address;
    logic [31:0]       sdram_wdata;
    logic              sdram_wnext;
    logic              sdram_complete;

    modport master (
        output sdram_request, sdram_address, sdram_wdata,
        input  sdram_ready, sdram_wnext, sdram_complete
    );

    modport slave (
        input  sdram_request, sdram_address, sdram_wdata,
        output sdram_ready, sdram_wnext, sdram_complete
    );
endinterface

// File: rtl/audio_writemem.sv
// ---------------------------------------------------------------------------
// audio_writemem
//   Audio capture write-back buffer. The block packs the high byte of each
//   16-bit sample into a byte stream. Sample n lives at byte n, little-endian
//   within each word. The block gathers the bytes into ping/pong lines of
//   LINE_WORDS x 32 bits and writes each full line to SDRAM as one burst.
//
//   Build option: define AUDIO_WRITEMEM_FLUSH_EN so that cfg_stop pads a
//   partial line with zeros and writes it. Without the option, cfg_stop
//   discards the partial line.
//
//   Ports:
//     clock, reset       system clock; synchronous active-high reset
//     i_cfg_start        pulse: begin capture (ignored while busy)
//     i_cfg_stop         pulse: end capture early (ignored in idle)
//     i_cfg_base         buffer start address (line offset bits ignored)
//     i_cfg_length       buffer length in bytes (line offset bits ignored)
//     i_cfg_loop         wrap to base at the end of the buffer
//     i_smp_valid        sample present this cycle (no backpressure)
//     i_smp_data         signed sample; only [15:8] is stored
//     sdram              SDRAM burst-write port (master modport)
//     o_busy             capture active or a burst is outstanding
//     o_done             1-cycle pulse when the final line is written
//     o_overflow         sticky: a sample was dropped
//     o_cap_state        debug: capture FSM state
//     o_wr_state         debug: write FSM state
// ---------------------------------------------------------------------------
module audio_writemem #(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_cfg_start,
    input  logic              i_cfg_stop,
    input  logic [ADDR_W-1:0] i_cfg_base,
    input  logic [ADDR_W-1:0] i_cfg_length,
    input  logic              i_cfg_loop,
    input  logic              i_smp_valid,
    input  logic [15:0]       i_smp_data,
    audio_writemem_if.master  sdram,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [1:0]        o_cap_state,
    output logic [1:0]        o_wr_state
);
    localparam int LINE_BYTES = LINE_WORDS * 4;
    localparam int BC_W       = $clog2(LINE_BYTES);
    localparam int WD_W       = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_INC   = ADDR_W'(LINE_BYTES);
    localparam logic [WD_W-1:0]   LAST_WORD  = WD_W'(LINE_WORDS - 1);
    localparam logic [WD_W:0]     FULL_WORDS = (WD_W + 1)'(LINE_WORDS);

    typedef enum logic [1:0] {C_IDLE, C_CAPTURE, C_DRAIN} cap_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_DATA}      wr_state_t;

    cap_state_t        r_cap_state;
    wr_state_t         r_wr_state;
    logic [ADDR_W-1:0] r_base, r_len, r_offset, r_fill_off, r_address;
    logic              r_loop, r_fill, r_wr_buf, r_request, r_done, r_overflow;
    logic [1:0]        r_pending;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [WD_W-1:0]   r_word;
    logic [31:0]       r_buf [2][LINE_WORDS];
    // Number of words holding captured data; later words read back as zero.
    logic [WD_W:0]     r_line_words [2];

    logic [ADDR_W-1:0] w_base_al, w_len_al, w_fill_off_nx, w_offset_nx;
    logic [WD_W-1:0]   w_wsel;
    logic [1:0]        w_lane, w_pending_left;
    logic              w_accept, w_complete, w_line_full;
    logic              w_unused;

    assign w_base_al     = {i_cfg_base[ADDR_W-1:BC_W], {BC_W{1'b0}}};
    assign w_len_al      = {i_cfg_length[ADDR_W-1:BC_W], {BC_W{1'b0}}};
    assign w_fill_off_nx = r_fill_off + LINE_INC;
    assign w_offset_nx   = r_offset + LINE_INC;
    assign w_wsel        = r_byte_cnt[BC_W-1:2];
    assign w_lane        = r_byte_cnt[1:0];
    assign w_line_full   = (r_byte_cnt == {BC_W{1'b1}});
    assign w_complete    = (r_wr_state == W_DATA) && sdram.sdram_complete;
    // cfg_stop takes priority over a sample arriving in the same cycle.
    assign w_accept      = (r_cap_state == C_CAPTURE) && i_smp_valid &&
                           !i_cfg_stop && !r_pending[r_fill];
    assign w_unused      = ^{i_smp_data[7:0], i_cfg_base[BC_W-1:0], i_cfg_length[BC_W-1:0]};

`ifdef AUDIO_WRITEMEM_FLUSH_EN
    logic [BC_W:0] w_bc_round;
    assign w_bc_round = {1'b0, r_byte_cnt} + (BC_W + 1)'(3);
`endif

    // Pending lines left once this cycle's completion (if any) is retired.
    always_comb begin
        w_pending_left = r_pending;
        if (w_complete) w_pending_left[r_wr_buf] = 1'b0;
    end

    assign o_busy         = (r_cap_state != C_IDLE) || (|r_pending) || (r_wr_state != W_IDLE);
    assign o_done         = r_done;
    assign o_overflow     = r_overflow;
    assign o_cap_state    = r_cap_state;
    assign o_wr_state     = r_wr_state;
    assign sdram.sdram_request = r_request;
    assign sdram.sdram_address = r_address;
    assign sdram.sdram_wdata   = ((r_wr_state == W_DATA) && ({1'b0, r_word} < r_line_words[r_wr_buf]))
                               ? r_buf[r_wr_buf][r_word] : 32'h0;

    // Line storage. The first byte of each word also clears its upper lanes,
    // so a partial last word is already zero-padded.
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            if (w_lane == 2'd0) r_buf[r_fill][w_wsel] <= {24'h0, i_smp_data[15:8]};
            else                r_buf[r_fill][w_wsel][{w_lane, 3'b000} +: 8] <= i_smp_data[15:8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cap_state     <= C_IDLE;
            r_wr_state      <= W_IDLE;
            r_base          <= '0;
            r_len           <= '0;
            r_offset        <= '0;
            r_fill_off      <= '0;
            r_address       <= '0;
            r_loop          <= 1'b0;
            r_fill          <= 1'b0;
            r_wr_buf        <= 1'b0;
            r_request       <= 1'b0;
            r_done          <= 1'b0;
            r_overflow      <= 1'b0;
            r_pending       <= 2'b00;
            r_byte_cnt      <= '0;
            r_word          <= '0;
            r_line_words[0] <= FULL_WORDS;
            r_line_words[1] <= FULL_WORDS;
        end else begin
            r_done <= 1'b0;

            // Write FSM. Lines are written in fill order, so the oldest
            // pending line is always r_wr_buf.
            case (r_wr_state)
                W_IDLE: if (r_pending[r_wr_buf]) begin
                    r_wr_state <= W_REQ;
                    r_request  <= 1'b1;
                    r_address  <= r_base + r_offset;
                end
                W_REQ: if (r_request && sdram.sdram_ready) begin
                    r_wr_state <= W_DATA;
                    r_request  <= 1'b0;
                    r_word     <= '0;
                end
                W_DATA: begin
                    if (sdram.sdram_complete) begin
                        r_pending[r_wr_buf] <= 1'b0;
                        r_wr_buf            <= ~r_wr_buf;
                        r_offset            <= (w_offset_nx == r_len) ? '0 : w_offset_nx;
                        r_wr_state          <= W_IDLE;
                    end else if (sdram.sdram_wnext && (r_word != LAST_WORD)) begin
                        r_word <= r_word + 1'b1;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase

            // Capture FSM. The line fill sets pending[r_fill]. Any completion
            // in the same cycle clears the other buffer, so both updates hold.
            case (r_cap_state)
                C_IDLE: if (i_cfg_start && !o_busy) begin
                    r_base     <= w_base_al;
                    r_len      <= w_len_al;
                    r_loop     <= i_cfg_loop;
                    r_offset   <= '0;
                    r_fill_off <= '0;
                    r_byte_cnt <= '0;
                    r_fill     <= 1'b0;
                    r_wr_buf   <= 1'b0;
                    r_overflow <= 1'b0;
                    if (w_len_al == '0) r_done      <= 1'b1;
                    else                r_cap_state <= C_CAPTURE;
                end
                C_CAPTURE: begin
                    if (i_cfg_stop) begin
                        r_byte_cnt <= '0;
`ifdef AUDIO_WRITEMEM_FLUSH_EN
                        if (r_byte_cnt != '0) begin
                            r_pending[r_fill]    <= 1'b1;
                            r_line_words[r_fill] <= w_bc_round[BC_W:2];
                            r_fill               <= ~r_fill;
                            r_cap_state          <= C_DRAIN;
                        end else
`endif
                        if (w_pending_left == 2'b00) begin
                            r_done      <= 1'b1;
                            r_cap_state <= C_IDLE;
                        end else begin
                            r_cap_state <= C_DRAIN;
                        end
                    end else if (i_smp_valid) begin
                        if (r_pending[r_fill]) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            if (w_line_full) begin
                                r_pending[r_fill]    <= 1'b1;
                                r_line_words[r_fill] <= FULL_WORDS;
                                r_fill               <= ~r_fill;
                                if (w_fill_off_nx == r_len) begin
                                    // Last line of the buffer has filled.
                                    r_fill_off <= '0;
                                    if (!r_loop) r_cap_state <= C_DRAIN;
                                end else begin
                                    r_fill_off <= w_fill_off_nx;
                                end
                            end
                        end
                    end
                end
                // Samples are ignored here. Done fires on the edge that
                // retires the last outstanding line.
                C_DRAIN: if (w_pending_left == 2'b00) begin
                    r_done      <= 1'b1;
                    r_cap_state <= C_IDLE;
                end
                default: r_cap_state <= C_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_writemem.sv
// ---------------------------------------------------------------------------
// tb_audio_writemem
//   Self-checking bench for audio_writemem. Expected burst addresses and
//   words are queued when samples are driven. An SDRAM slave model pops and
//   compares them as the DUT writes each burst.
// ---------------------------------------------------------------------------
module tb_audio_writemem;
    localparam int ADDR_W = 26;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic              cfg_start = 1'b0, cfg_stop = 1'b0, cfg_loop = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0, cfg_length = '0;
    logic              smp_valid = 1'b0;
    logic [15:0]       smp_data = '0;
    logic              o_busy, o_done, o_overflow;
    logic [1:0]        o_cap_state, o_wr_state;

    audio_writemem_if #(.ADDR_W(ADDR_W)) bus ();

    audio_writemem #(.LINE_WORDS(16), .ADDR_W(ADDR_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .i_cfg_start (cfg_start),
        .i_cfg_stop  (cfg_stop),
        .i_cfg_base  (cfg_base),
        .i_cfg_length(cfg_length),
        .i_cfg_loop  (cfg_loop),
        .i_smp_valid (smp_valid),
        .i_smp_data  (smp_data),
        .sdram       (bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_overflow  (o_overflow),
        .o_cap_state (o_cap_state),
        .o_wr_state  (o_wr_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          burst_cnt = 0;
    int          done_cnt = 0;
    int          slave_word = -1;
    bit          slave_en = 1'b1;
    int          ready_delay = 0;
    logic        done_after_cpl = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clock) if (o_done) done_cnt++;

    // ---------------- SDRAM slave model ----------------
    initial begin
        bit aborted;
        bus.sdram_ready    = 1'b0;
        bus.sdram_wnext    = 1'b0;
        bus.sdram_complete = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && slave_en && bus.sdram_request) begin
                repeat (ready_delay) @(negedge clock);
                if (exp_addr_q.size() == 0)
                    check("addr_sb_empty", 32'(exp_addr_q.size()), 32'd1);
                else
                    check("burst_addr", 32'(bus.sdram_address), exp_addr_q.pop_front());
                burst_cnt++;
                bus.sdram_ready = 1'b1;
                @(negedge clock);
                bus.sdram_ready = 1'b0;
                aborted = 1'b0;
                for (int w = 0; w < 16; w++) begin
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    slave_word = w;
                    if (exp_q.size() == 0)
                        check("wdata_sb_empty", 32'(exp_q.size()), 32'd1);
                    else
                        check("burst_wdata", bus.sdram_wdata, exp_q.pop_front());
                    bus.sdram_wnext = 1'b1;
                    @(negedge clock);
                end
                bus.sdram_wnext = 1'b0;
                if (!aborted && !reset) begin
                    bus.sdram_complete = 1'b1;
                    @(negedge clock);
                    bus.sdram_complete = 1'b0;
                    done_after_cpl = o_done;
                end
                slave_word = -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_line(input logic [31:0] addr, input int first, input int count);
        logic [31:0] word;
        int          idx;
        exp_addr_q.push_back(addr);
        for (int w = 0; w < 16; w++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                idx = 4 * w + k;
                if (idx < count) word[8*k +: 8] = 8'(first + idx);
            end
            exp_q.push_back(word);
        end
    endtask

    task automatic start_capture(input logic [31:0] base, input logic [31:0] len, input logic loop);
        @(negedge clock);
        cfg_base   = base[ADDR_W-1:0];
        cfg_length = len[ADDR_W-1:0];
        cfg_loop   = loop;
        cfg_start  = 1'b1;
        @(negedge clock);
        cfg_start  = 1'b0;
    endtask

    task automatic stop_capture();
        cfg_stop = 1'b1;
        @(negedge clock);
        cfg_stop = 1'b0;
    endtask

    task automatic send_samples(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            smp_valid = 1'b1;
            smp_data  = {8'(first + i), 8'($urandom_range(0, 255))};
            @(negedge clock);
        end
        smp_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    task automatic wait_sb_empty(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic settle();
        repeat (2) @(negedge clock);
    endtask

    task automatic run_basic(input string tag);
        int d0, b0;
        d0 = done_cnt;
        b0 = burst_cnt;
        done_after_cpl = 1'b0;
        start_capture(32'h1000, 32'd64, 1'b0);
        check({tag, "_busy_start"}, 32'(o_busy), 32'd1);
        expect_line(32'h1000, 0, 64);
        send_samples(64, 0);
        wait_idle({tag, "_idle"}, 500);
        settle();
        check({tag, "_done_after_cpl"}, 32'(done_after_cpl), 32'd1);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_bursts"}, 32'(burst_cnt - b0), 32'd1);
        check({tag, "_overflow"}, 32'(o_overflow), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog sim_time_exceeded");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int d0, b0, n;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_request",  32'(bus.sdram_request), 32'd0);
        check("rst_address",  32'(bus.sdram_address), 32'd0);
        check("rst_wdata",    bus.sdram_wdata, 32'd0);
        check("rst_busy",     32'(o_busy), 32'd0);
        check("rst_done",     32'(o_done), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_cap_state", 32'(o_cap_state), 32'd0);
        check("rst_wr_state",  32'(o_wr_state), 32'd0);

        // 1: single line, done right after complete
        run_basic("t1");

        // Length field zero (low bits ignored): done next cycle, no burst
        b0 = burst_cnt;
        start_capture(32'h7000, 32'h3F, 1'b0);
        check("len0_done", 32'(o_done), 32'd1);
        check("len0_busy", 32'(o_busy), 32'd0);
        settle();
        check("len0_bursts", 32'(burst_cnt - b0), 32'd0);

        // 2: two lines, delayed ready
        d0 = done_cnt;
        b0 = burst_cnt;
        ready_delay = 10;
        start_capture(32'h2040, 32'd128, 1'b0);
        expect_line(32'h2040, 0, 64);
        expect_line(32'h2080, 64, 64);
        send_samples(128, 0);
        wait_idle("t2_idle", 1000);
        settle();
        ready_delay = 0;
        check("t2_overflow", 32'(o_overflow), 32'd0);
        check("t2_bursts", 32'(burst_cnt - b0), 32'd2);
        check("t2_done_count", 32'(done_cnt - d0), 32'd1);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: controller stalled, 129th sample overflows
        d0 = done_cnt;
        b0 = burst_cnt;
        slave_en = 1'b0;
        start_capture(32'h4000, 32'd256, 1'b0);
        expect_line(32'h4000, 0, 64);
        expect_line(32'h4040, 64, 64);
        send_samples(128, 0);
        check("t3_ovf_before", 32'(o_overflow), 32'd0);
        send_samples(1, 128);
        check("t3_ovf_after", 32'(o_overflow), 32'd1);
        stop_capture();
        check("t3_drain_state", 32'(o_cap_state), 32'd2);
        slave_en = 1'b1;
        wait_idle("t3_idle", 1000);
        settle();
        check("t3_bursts", 32'(burst_cnt - b0), 32'd2);
        check("t3_done_count", 32'(done_cnt - d0), 32'd1);
        check("t3_ovf_sticky", 32'(o_overflow), 32'd1);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: loop mode, both lines at base, no done while looping
        d0 = done_cnt;
        b0 = burst_cnt;
        start_capture(32'h3000, 32'd64, 1'b1);
        start_capture(32'h9000, 32'd64, 1'b0);   // ignored while busy
        check("t4_cap_state", 32'(o_cap_state), 32'd1);
        expect_line(32'h3000, 0, 64);
        expect_line(32'h3000, 64, 64);
        send_samples(128, 0);
        wait_sb_empty("t4_sb_empty", 500);
        settle();
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_still_busy", 32'(o_busy), 32'd1);
        stop_capture();
        wait_idle("t4_idle", 200);
        settle();
        check("t4_bursts", 32'(burst_cnt - b0), 32'd2);
        check("t4_done_on_stop", 32'(done_cnt - d0), 32'd1);

        // 5: reset in the middle of a burst
        slave_en = 1'b0;
        start_capture(32'h5000, 32'd256, 1'b0);
        expect_line(32'h5000, 0, 64);
        expect_line(32'h5040, 64, 64);
        send_samples(129, 0);
        check("t5_ovf_set", 32'(o_overflow), 32'd1);
        slave_en = 1'b1;
        n = 0;
        while (slave_word < 7 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t5_reached_word7", 32'(slave_word >= 7), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("t5_request", 32'(bus.sdram_request), 32'd0);
        check("t5_busy", 32'(o_busy), 32'd0);
        check("t5_overflow", 32'(o_overflow), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        settle();
        run_basic("t5_fresh");

        // 6: ten samples then stop
        d0 = done_cnt;
        b0 = burst_cnt;
        done_after_cpl = 1'b0;
        start_capture(32'h6000, 32'd256, 1'b0);
`ifdef AUDIO_WRITEMEM_FLUSH_EN
        expect_line(32'h6000, 0, 10);
        send_samples(10, 0);
        stop_capture();
        wait_idle("t6_idle", 200);
        settle();
        check("t6_bursts", 32'(burst_cnt - b0), 32'd1);
        check("t6_done_after_cpl", 32'(done_after_cpl), 32'd1);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
`else
        send_samples(10, 0);
        stop_capture();
        check("t6_done_next", 32'(o_done), 32'd1);
        check("t6_busy", 32'(o_busy), 32'd0);
        settle();
        check("t6_bursts", 32'(burst_cnt - b0), 32'd0);
`endif
        check("t6_done_count", 32'(done_cnt - d0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
